vxe_cu_cmd_dispatch: RTL and testbench
======================================

Name: vxe_cu_cmd_dispatch

Overview:
Registered command decoder and dispatcher for the VxE control unit. Accepts 64-bit command words from the CU fetch path over a valid/ready handshake, and decodes and format-checks them. Routes CU-class commands (NOP/SYNC) to the CU sequencer and VPU-class commands to per-VPU issue ports. Broadcast commands are tracked per VPU, so slow VPUs do not block handshakes already completed by others. Decode errors are latched and halt intake until cleared.

Parameters:
VPUS_NR, 2, number of VPUs, 1..32; the VPU index is dst[7:3].
VERIFY_FMT, 1, nonzero enables dst, zero-field and payload format checks.

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
i_cmd  in  64  command word: op[63:59], dst[58:51], zero[50:48], pl[47:0]
i_cmd_valid  in  1  command word valid
o_cmd_ready  out  1  dispatcher accepts i_cmd this cycle
o_cu_valid  out  1  CU command valid
i_cu_ready  in  1  CU sequencer accepts
o_cu_nop  out  1  decoded NOP
o_cu_sync  out  1  decoded SYNC
o_cu_sync_stop  out  1  SYNC pl[0]
o_cu_sync_intr  out  1  SYNC pl[1]
o_vpu_valid  out  VPUS_NR  per-VPU command valid (pending mask)
i_vpu_ready  in  VPUS_NR  per-VPU accept
o_vpu_op  out  5  opcode
o_vpu_th  out  3  thread, dst[2:0]
o_vpu_pl  out  48  payload
o_err  out  1  sticky decode error
o_err_cmd  out  64  offending command word
i_err_clr  in  1  single-cycle pulse; clears error state
o_busy  out  1  decode register occupied

Behaviour:
- Reset (nrst=0, async): o_cu_valid=0, o_vpu_valid=0, o_err=0, o_err_cmd=0, o_busy=0, all data outputs 0. After reset, o_cmd_ready=1.
- Class: CU if op[4:2]==0, else VPU. Broadcast if op[4]=1 and dst[0]=0; the mask is then all ones. Otherwise the mask is one-hot on dst[7:3].
- Decode error: any of the following.
  - Opcode not in the CU_CMD_* set.
  - ACTF function not RELU/LRELU.
  - VPU index >= VPUS_NR.
  - If VERIFY_FMT: zero field nonzero; dst nonzero for NOP/SYNC; for PROD/STORE/ACTF, dst!=0 when broadcast-enabled or dst[2:1]!=0 otherwise; payload reserved bits set per opcode. Reserved bits: NOP/PROD/STORE pl[47:0]; SYNC pl[47:2]; SETACC pl[47:32]; SETVL pl[47:20]; SETRS/RT/RD pl[47:38]; SETEN pl[47:1]; ACTF RELU pl[41:0], LRELU pl[41:7].
- Single decode register. A command accepted at cycle N presents outputs at N+1; latency 1.
- drain = (CU entry and o_cu_valid and i_cu_ready) or (VPU entry and (o_vpu_valid & ~i_vpu_ready)==0).
- o_cmd_ready = ~o_err and (~o_busy or drain). This path is combinational, giving back-to-back throughput of 1 command/cycle.
- VPU pending mask:
  - Load with the decoded mask on accept.
  - Each bit clears on o_vpu_valid[i] and i_vpu_ready[i].
  - The entry retires when all bits are clear.
  - o_vpu_op/th/pl stay stable while any bit is pending.
- CU entry: o_cu_valid is held until i_cu_ready. CU fields stay stable while valid.
- Erroneous command:
  - Consumed (ready=1 that cycle), never issued.
  - Next cycle: o_err=1, o_err_cmd=i_cmd, o_cmd_ready=0.
  - An entry already in the decode register still drains normally.
- i_err_clr with o_err=1: o_err=0 and o_err_cmd=0 next cycle; intake resumes the following cycle. i_err_clr with o_err=0 has no effect.
- Accept and drain in the same cycle: the register reloads with the new command, with no bubble.
- Valid outputs never deassert without a handshake, except on reset. Reset mid-broadcast drops all pending bits.
- Outputs are driven from registers only, except o_cmd_ready.

Decomposition:
- Opcode, ACTF and field constants (CU_CMD_*, CU_CMD_ACTF_*) come from the shared vxe_ctrl_unit_cmds.vh include. Add the field-position constants there as well.
- One combinational sub-module, vxe_cu_cmd_fields (parameters VPUS_NR, VERIFY_FMT): produces the class, mask, error flag and CU/VPU fields from the raw word.
- The top level holds the decode register, pending mask, error latch and handshake logic.

Test Plan:
1. SYNC word 64'h0800_0000_0000_0003 with i_cu_ready=1 -> next cycle o_cu_valid=1, sync=1, stop=1, intr=1, nop=0. Valid lasts one cycle.
2. VPUS_NR=4, broadcast PROD (dst=0). i_vpu_ready=4'b0101, then 4'b1010 the next cycle -> o_vpu_valid goes 1111, 1010, 0000. o_cmd_ready=0 until the final cycle. The next command is accepted in that same cycle.
3. Non-broadcast SETVL, dst=8'h10 (VPU2, th0), pl=20'hABCDE -> o_vpu_valid=4'b0100, o_vpu_pl=48'h0_000A_BCDE, th=0.
4. VPU index 5 with VPUS_NR=4 -> command consumed, no valid raised; o_err=1 and o_err_cmd=word next cycle; o_cmd_ready=0. One cycle after i_err_clr, a NOP is accepted.
5. NOP with pl[3]=1 -> error with VERIFY_FMT=1. With VERIFY_FMT=0 it issues as a NOP.
6. Ten back-to-back STORE commands to VPU0 with i_vpu_ready=1 -> ten valid cycles, no bubbles. Assert nrst mid-stream -> all valids 0 immediately.

Source files
------------

// File: rtl/vxe_cu_cmd_dispatch_pkg.sv
// Shared types and helpers for the CU command dispatcher.
//   ent_e        : occupancy/class of the single decode register
//   cu_fields_t  : decoded fields presented to the CU sequencer
//   vpu_fields_t : decoded fields presented on the VPU issue ports
//   pl_rsv_mask  : payload bits that must be zero for a given opcode
package vxe_cu_cmd_dispatch_pkg;

`include "vxe_ctrl_unit_cmds.vh"

   typedef enum logic [1:0] {
      ENT_EMPTY = 2'd0,
      ENT_CU    = 2'd1,
      ENT_VPU   = 2'd2
   } ent_e;

   typedef struct packed {
      logic nop;
      logic sync;
      logic stop;
      logic intr;
   } cu_fields_t;

   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  th;
      logic [47:0] pl;
   } vpu_fields_t;

   // Reserved payload bits per opcode. An ACTF with an unknown function is
   // already an error on its own, so it reports no reserved bits here.
   function automatic logic [47:0] pl_rsv_mask(input logic [4:0] op,
                                                input logic [5:0] func);
      logic [47:0] m;
      m = 48'h0;
      case (op)
         CU_CMD_NOP, CU_CMD_PROD, CU_CMD_STORE: m = 48'hFFFF_FFFF_FFFF;
         CU_CMD_SYNC:   m = 48'hFFFF_FFFF_FFFC;
         CU_CMD_SETACC: m = 48'hFFFF_0000_0000;
         CU_CMD_SETVL:  m = 48'hFFFF_FFF0_0000;
         CU_CMD_SETRS, CU_CMD_SETRT, CU_CMD_SETRD: m = 48'hFFC0_0000_0000;
         CU_CMD_SETEN:  m = 48'hFFFF_FFFF_FFFE;
         CU_CMD_ACTF: begin
            if (func == CU_CMD_ACTF_RELU)       m = 48'h03FF_FFFF_FFFF;
            else if (func == CU_CMD_ACTF_LRELU) m = 48'h03FF_FFFF_FF80;
            else                                m = 48'h0;
         end
         default: m = 48'h0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/vxe_ctrl_unit_cmds.vh
// VxE control-unit command set: opcodes, ACTF function codes and the bit
// positions of the fields inside a 64-bit command word. Included inside a
// package so every consumer sees the same constants through an import.
`ifndef VXE_CTRL_UNIT_CMDS_VH
`define VXE_CTRL_UNIT_CMDS_VH

// CU-class opcodes (op[4:2] == 0)
localparam logic [4:0] CU_CMD_NOP    = 5'h00;
localparam logic [4:0] CU_CMD_SYNC   = 5'h01;
// VPU-class unicast-only opcodes
localparam logic [4:0] CU_CMD_SETACC = 5'h04;
localparam logic [4:0] CU_CMD_SETVL  = 5'h05;
localparam logic [4:0] CU_CMD_SETRS  = 5'h06;
localparam logic [4:0] CU_CMD_SETRT  = 5'h07;
localparam logic [4:0] CU_CMD_SETRD  = 5'h08;
localparam logic [4:0] CU_CMD_SETEN  = 5'h09;
// VPU-class broadcast-capable opcodes (op[4] == 1)
localparam logic [4:0] CU_CMD_PROD   = 5'h10;
localparam logic [4:0] CU_CMD_STORE  = 5'h11;
localparam logic [4:0] CU_CMD_ACTF   = 5'h12;

// ACTF function codes, carried in the payload function field
localparam logic [5:0] CU_CMD_ACTF_RELU  = 6'd0;
localparam logic [5:0] CU_CMD_ACTF_LRELU = 6'd1;

// Command word field positions
localparam int CU_CMD_OP_MSB   = 63;
localparam int CU_CMD_OP_LSB   = 59;
localparam int CU_CMD_DST_MSB  = 58;
localparam int CU_CMD_DST_LSB  = 51;
localparam int CU_CMD_ZERO_MSB = 50;
localparam int CU_CMD_ZERO_LSB = 48;
localparam int CU_CMD_PL_MSB   = 47;
localparam int CU_CMD_PL_LSB   = 0;
// ACTF function field, positions relative to the payload
localparam int CU_CMD_ACTF_FUNC_MSB = 47;
localparam int CU_CMD_ACTF_FUNC_LSB = 42;

`endif

// File: rtl/vxe_cu_cmd_fields.sv
// Combinational decoder for one 64-bit CU command word.
//   cmd     : raw command word
//   is_cu   : command belongs to the CU sequencer (NOP/SYNC class)
//   dec_err : word is illegal and must not be issued
//   mask    : VPU destination mask (all ones for broadcast)
//   cu_f    : NOP/SYNC decode and SYNC flags
//   vpu_f   : opcode, thread and payload for the VPU issue ports
module vxe_cu_cmd_fields
   import vxe_cu_cmd_dispatch_pkg::*;
#(
   parameter int VPUS_NR    = 2,
   parameter int VERIFY_FMT = 1
) (
   input  logic [63:0]        cmd,
   output logic               is_cu,
   output logic               dec_err,
   output logic [VPUS_NR-1:0] mask,
   output cu_fields_t         cu_f,
   output vpu_fields_t        vpu_f
);

   logic [4:0]  op;
   logic [7:0]  dst;
   logic [2:0]  zf;
   logic [47:0] pl;
   logic [5:0]  func;
   logic [4:0]  vidx;
   logic        bcast_cap;
   logic        bcast;
   logic        known_op;
   logic        func_err;
   logic        idx_err;
   logic        fmt_err;

   assign op   = cmd[CU_CMD_OP_MSB:CU_CMD_OP_LSB];
   assign dst  = cmd[CU_CMD_DST_MSB:CU_CMD_DST_LSB];
   assign zf   = cmd[CU_CMD_ZERO_MSB:CU_CMD_ZERO_LSB];
   assign pl   = cmd[CU_CMD_PL_MSB:CU_CMD_PL_LSB];
   assign func = pl[CU_CMD_ACTF_FUNC_MSB:CU_CMD_ACTF_FUNC_LSB];
   assign vidx = dst[7:3];

   assign is_cu     = (op[4:2] == 3'd0);
   assign bcast_cap = op[4];
   // dst[0] low on a broadcast-capable opcode selects every VPU
   assign bcast     = bcast_cap & ~dst[0];

   always_comb begin
      known_op = 1'b0;
      case (op)
         CU_CMD_NOP, CU_CMD_SYNC,
         CU_CMD_SETACC, CU_CMD_SETVL, CU_CMD_SETRS, CU_CMD_SETRT,
         CU_CMD_SETRD, CU_CMD_SETEN,
         CU_CMD_PROD, CU_CMD_STORE, CU_CMD_ACTF: known_op = 1'b1;
         default:                                known_op = 1'b0;
      endcase
   end

   assign func_err = (op == CU_CMD_ACTF) &&
                     (func != CU_CMD_ACTF_RELU) && (func != CU_CMD_ACTF_LRELU);

   // Only unicast VPU commands address a specific VPU
   assign idx_err = ~is_cu & ~bcast & ({1'b0, vidx} >= 6'(VPUS_NR));

   always_comb begin
      fmt_err = (zf != 3'd0) || ((pl & pl_rsv_mask(op, func)) != 48'h0);
      if ((op == CU_CMD_NOP || op == CU_CMD_SYNC) && dst != 8'h00)
         fmt_err = 1'b1;
      if (bcast_cap) begin
         // A broadcast carries no VPU/thread; a unicast has no thread bits
         if (bcast) begin
            if (dst != 8'h00) fmt_err = 1'b1;
         end else begin
            if (dst[2:1] != 2'b00) fmt_err = 1'b1;
         end
      end
   end

   assign dec_err = ~known_op | func_err | idx_err |
                    ((VERIFY_FMT != 0) & fmt_err);

   generate
      for (genvar gi = 0; gi < VPUS_NR; gi++) begin : g_mask
         assign mask[gi] = bcast | (vidx == 5'(gi));
      end
   endgenerate

   always_comb begin
      cu_f.nop  = (op == CU_CMD_NOP);
      cu_f.sync = (op == CU_CMD_SYNC);
      cu_f.stop = pl[0];
      cu_f.intr = pl[1];
   end

   always_comb begin
      vpu_f.op = op;
      vpu_f.th = dst[2:0];
      vpu_f.pl = pl;
   end

endmodule

// File: rtl/vxe_cu_cmd_dispatch.sv
// VxE CU command dispatcher: a single registered decode stage between the
// CU fetch path and the CU sequencer / per-VPU issue ports.
//   clk, nrst                       : clock, asynchronous active-low reset
//   i_cmd, i_cmd_valid, o_cmd_ready : command intake handshake
//   o_cu_valid, i_cu_ready          : CU sequencer handshake
//   o_cu_nop/sync/sync_stop/intr    : CU command fields
//   o_vpu_valid, i_vpu_ready        : per-VPU handshakes (pending mask)
//   o_vpu_op/th/pl                  : VPU command fields (shared by all VPUs)
//   o_err, o_err_cmd, i_err_clr     : sticky decode error and its clear
//   o_busy                          : decode register occupied
module vxe_cu_cmd_dispatch
   import vxe_cu_cmd_dispatch_pkg::*;
#(
   parameter int VPUS_NR    = 2,
   parameter int VERIFY_FMT = 1
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [63:0]        i_cmd,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   output logic               o_cu_valid,
   input  logic               i_cu_ready,
   output logic               o_cu_nop,
   output logic               o_cu_sync,
   output logic               o_cu_sync_stop,
   output logic               o_cu_sync_intr,
   output logic [VPUS_NR-1:0] o_vpu_valid,
   input  logic [VPUS_NR-1:0] i_vpu_ready,
   output logic [4:0]         o_vpu_op,
   output logic [2:0]         o_vpu_th,
   output logic [47:0]        o_vpu_pl,
   output logic               o_err,
   output logic [63:0]        o_err_cmd,
   input  logic               i_err_clr,
   output logic               o_busy
);

   logic               dec_is_cu;
   logic               dec_err;
   logic [VPUS_NR-1:0] dec_mask;
   cu_fields_t         dec_cu;
   vpu_fields_t        dec_vpu;

   vxe_cu_cmd_fields #(
      .VPUS_NR    (VPUS_NR),
      .VERIFY_FMT (VERIFY_FMT)
   ) u_fields (
      .cmd     (i_cmd),
      .is_cu   (dec_is_cu),
      .dec_err (dec_err),
      .mask    (dec_mask),
      .cu_f    (dec_cu),
      .vpu_f   (dec_vpu)
   );

   ent_e               ent_reg,      ent_next;
   logic               busy_reg,     busy_next;
   logic               cu_valid_reg, cu_valid_next;
   cu_fields_t         cu_reg,       cu_next;
   logic [VPUS_NR-1:0] pend_reg,     pend_next;
   vpu_fields_t        vpu_reg,      vpu_next;
   logic               err_reg,      err_next;
   logic [63:0]        err_cmd_reg,  err_cmd_next;

   logic [VPUS_NR-1:0] pend_left;
   logic               drain;
   logic               cmd_ready;
   logic               accept;

   // VPUs that have not yet taken the current entry after this cycle
   assign pend_left = pend_reg & ~i_vpu_ready;
   assign drain     = ((ent_reg == ENT_CU)  && i_cu_ready) ||
                      ((ent_reg == ENT_VPU) && (pend_left == '0));
   assign cmd_ready = ~err_reg & (~busy_reg | drain);
   assign accept    = i_cmd_valid & cmd_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ent_reg      <= ENT_EMPTY;
         busy_reg     <= 1'b0;
         cu_valid_reg <= 1'b0;
         cu_reg       <= '0;
         pend_reg     <= '0;
         vpu_reg      <= '0;
         err_reg      <= 1'b0;
         err_cmd_reg  <= 64'h0;
      end else begin
         ent_reg      <= ent_next;
         busy_reg     <= busy_next;
         cu_valid_reg <= cu_valid_next;
         cu_reg       <= cu_next;
         pend_reg     <= pend_next;
         vpu_reg      <= vpu_next;
         err_reg      <= err_next;
         err_cmd_reg  <= err_cmd_next;
      end
   end

   always_comb begin
      ent_next      = ent_reg;
      busy_next     = busy_reg;
      cu_valid_next = cu_valid_reg;
      cu_next       = cu_reg;
      pend_next     = pend_reg;
      vpu_next      = vpu_reg;
      err_next      = err_reg;
      err_cmd_next  = err_cmd_reg;

      if (ent_reg == ENT_VPU)
         pend_next = pend_left;

      if (drain) begin
         ent_next      = ENT_EMPTY;
         busy_next     = 1'b0;
         cu_valid_next = 1'b0;
         pend_next     = '0;
      end

      // A bad word is swallowed here; whatever already sits in the decode
      // register keeps draining through the logic above.
      if (accept && dec_err) begin
         err_next     = 1'b1;
         err_cmd_next = i_cmd;
      end else if (accept) begin
         busy_next = 1'b1;
         if (dec_is_cu) begin
            ent_next      = ENT_CU;
            cu_valid_next = 1'b1;
            cu_next       = dec_cu;
         end else begin
            ent_next  = ENT_VPU;
            pend_next = dec_mask;
            vpu_next  = dec_vpu;
         end
      end

      // Intake is blocked while the error is set, so this never races accept
      if (err_reg && i_err_clr) begin
         err_next     = 1'b0;
         err_cmd_next = 64'h0;
      end
   end

   assign o_cmd_ready    = cmd_ready;
   assign o_busy         = busy_reg;
   assign o_cu_valid     = cu_valid_reg;
   assign o_cu_nop       = cu_reg.nop;
   assign o_cu_sync      = cu_reg.sync;
   assign o_cu_sync_stop = cu_reg.stop;
   assign o_cu_sync_intr = cu_reg.intr;
   assign o_vpu_valid    = pend_reg;
   assign o_vpu_op       = vpu_reg.op;
   assign o_vpu_th       = vpu_reg.th;
   assign o_vpu_pl       = vpu_reg.pl;
   assign o_err          = err_reg;
   assign o_err_cmd      = err_cmd_reg;

endmodule

// File: tb/tb_vxe_cu_cmd_dispatch.sv
// Directed plus randomized bench for vxe_cu_cmd_dispatch with a
// transaction-level reference model of the dispatcher's rules.
module tb_vxe_cu_cmd_dispatch;
   import vxe_cu_cmd_dispatch_pkg::*;

   localparam int NV = 4;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [63:0]   i_cmd = 64'h0;
   logic          i_cmd_valid = 1'b0;
   logic          i_cu_ready = 1'b0;
   logic [NV-1:0] i_vpu_ready = '0;
   logic          i_err_clr = 1'b0;

   logic          o_cmd_ready, o_cu_valid, o_cu_nop, o_cu_sync;
   logic          o_cu_sync_stop, o_cu_sync_intr, o_err, o_busy;
   logic [NV-1:0] o_vpu_valid;
   logic [4:0]    o_vpu_op;
   logic [2:0]    o_vpu_th;
   logic [47:0]   o_vpu_pl;
   logic [63:0]   o_err_cmd;

   // second instance without format checking
   logic          cmd_valid2 = 1'b0;
   logic          cu_ready2 = 1'b1;
   logic [NV-1:0] vpu_ready2 = '1;
   logic          err_clr2 = 1'b0;
   logic          o2_cmd_ready, o2_cu_valid, o2_cu_nop, o2_cu_sync;
   logic          o2_cu_sync_stop, o2_cu_sync_intr, o2_err, o2_busy;
   logic [NV-1:0] o2_vpu_valid;
   logic [4:0]    o2_vpu_op;
   logic [2:0]    o2_vpu_th;
   logic [47:0]   o2_vpu_pl;
   logic [63:0]   o2_err_cmd;

   always #5 clk = ~clk;

   vxe_cu_cmd_dispatch #(.VPUS_NR(NV), .VERIFY_FMT(1)) dut (
      .clk(clk), .nrst(nrst), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready), .o_cu_valid(o_cu_valid), .i_cu_ready(i_cu_ready),
      .o_cu_nop(o_cu_nop), .o_cu_sync(o_cu_sync), .o_cu_sync_stop(o_cu_sync_stop),
      .o_cu_sync_intr(o_cu_sync_intr), .o_vpu_valid(o_vpu_valid),
      .i_vpu_ready(i_vpu_ready), .o_vpu_op(o_vpu_op), .o_vpu_th(o_vpu_th),
      .o_vpu_pl(o_vpu_pl), .o_err(o_err), .o_err_cmd(o_err_cmd),
      .i_err_clr(i_err_clr), .o_busy(o_busy));

   vxe_cu_cmd_dispatch #(.VPUS_NR(NV), .VERIFY_FMT(0)) dut_nofmt (
      .clk(clk), .nrst(nrst), .i_cmd(i_cmd), .i_cmd_valid(cmd_valid2),
      .o_cmd_ready(o2_cmd_ready), .o_cu_valid(o2_cu_valid), .i_cu_ready(cu_ready2),
      .o_cu_nop(o2_cu_nop), .o_cu_sync(o2_cu_sync), .o_cu_sync_stop(o2_cu_sync_stop),
      .o_cu_sync_intr(o2_cu_sync_intr), .o_vpu_valid(o2_vpu_valid),
      .i_vpu_ready(vpu_ready2), .o_vpu_op(o2_vpu_op), .o_vpu_th(o2_vpu_th),
      .o_vpu_pl(o2_vpu_pl), .o_err(o2_err), .o_err_cmd(o2_err_cmd),
      .i_err_clr(err_clr2), .o_busy(o2_busy));

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_cu_v, m_nop, m_sync, m_stop, m_intr, m_err;
   logic [3:0]  m_pend;
   logic [4:0]  m_op;
   logic [2:0]  m_th;
   logic [47:0] m_pl;
   logic [63:0] m_err_cmd;

   function automatic logic [63:0] mk(input logic [4:0] op, input logic [7:0] dst,
                                      input logic [2:0] z, input logic [47:0] pl);
      return {op, dst, z, pl};
   endfunction

   // Reserved payload range [hi:lo] for an opcode; returns 0 if none
   function automatic bit rsv_range(input logic [4:0] op, input logic [47:0] pl,
                                    output int hi, output int lo);
      logic [5:0] fn;
      fn = pl[47:42];
      hi = 47;
      lo = 0;
      if (op == CU_CMD_NOP || op == CU_CMD_PROD || op == CU_CMD_STORE) lo = 0;
      else if (op == CU_CMD_SYNC)   lo = 2;
      else if (op == CU_CMD_SETACC) lo = 32;
      else if (op == CU_CMD_SETVL)  lo = 20;
      else if (op == CU_CMD_SETRS || op == CU_CMD_SETRT || op == CU_CMD_SETRD) lo = 38;
      else if (op == CU_CMD_SETEN)  lo = 1;
      else if (op == CU_CMD_ACTF && fn == 6'd0) begin hi = 41; lo = 0; end
      else if (op == CU_CMD_ACTF && fn == 6'd1) begin hi = 41; lo = 7; end
      else return 1'b0;
      return 1'b1;
   endfunction

   function automatic longint unsigned range_bits(input int hi, input int lo);
      longint unsigned one;
      one = 1;
      return ((one << (hi - lo + 1)) - 1) << lo;
   endfunction

   function automatic void ref_dec(input logic [63:0] w, output bit err,
                                   output bit cu, output logic [3:0] mask);
      logic [4:0]  op;
      logic [7:0]  dst;
      logic [47:0] pl;
      int          vidx, hi, lo;
      bit          bc, known;
      longint unsigned plx;
      op   = w[63:59];
      dst  = w[58:51];
      pl   = w[47:0];
      plx  = {16'h0, pl};
      cu   = (op < 5'd4);
      bc   = (op >= 5'd16) && (dst[0] == 1'b0);
      vidx = int'(dst) / 8;
      known = (op == CU_CMD_NOP) || (op == CU_CMD_SYNC) ||
              (op >= CU_CMD_SETACC && op <= CU_CMD_SETEN) ||
              (op >= CU_CMD_PROD && op <= CU_CMD_ACTF);
      err = !known;
      if (op == CU_CMD_ACTF && pl[47:42] > 6'd1) err = 1'b1;
      if (!cu && !bc && vidx >= NV) err = 1'b1;
      if (w[50:48] != 3'd0) err = 1'b1;
      if ((op == CU_CMD_NOP || op == CU_CMD_SYNC) && dst != 8'h00) err = 1'b1;
      if (op >= 5'd16) begin
         if (bc && dst != 8'h00) err = 1'b1;
         if (!bc && ((dst / 2) % 4) != 0) err = 1'b1;
      end
      if (rsv_range(op, pl, hi, lo))
         if ((plx & range_bits(hi, lo)) != 0) err = 1'b1;
      mask = bc ? 4'hF : ((vidx < NV) ? 4'(1 << vidx) : 4'h0);
   endfunction

   function automatic bit m_busy();
      return m_cu_v || (m_pend != 4'h0);
   endfunction

   function automatic bit m_drain();
      if (m_cu_v) return i_cu_ready;
      if (m_pend != 4'h0) return (m_pend & ~i_vpu_ready) == 4'h0;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      return !m_err && (!m_busy() || m_drain());
   endfunction

   task automatic model_reset();
      m_cu_v = 0; m_nop = 0; m_sync = 0; m_stop = 0; m_intr = 0; m_err = 0;
      m_pend = 4'h0; m_op = 5'h0; m_th = 3'h0; m_pl = 48'h0; m_err_cmd = 64'h0;
   endtask

   task automatic model_step();
      bit acc, old_err, e, cu;
      logic [3:0] mask;
      acc     = i_cmd_valid && m_ready();
      old_err = m_err;
      if (m_cu_v && i_cu_ready) m_cu_v = 0;
      m_pend = m_pend & ~i_vpu_ready;
      if (acc) begin
         ref_dec(i_cmd, e, cu, mask);
         if (e) begin
            m_err = 1;
            m_err_cmd = i_cmd;
         end else if (cu) begin
            m_cu_v = 1;
            m_nop  = (i_cmd[63:59] == CU_CMD_NOP);
            m_sync = (i_cmd[63:59] == CU_CMD_SYNC);
            m_stop = i_cmd[0];
            m_intr = i_cmd[1];
         end else begin
            m_pend = mask;
            m_op = i_cmd[63:59];
            m_th = i_cmd[53:51];
            m_pl = i_cmd[47:0];
         end
      end
      if (old_err && i_err_clr) begin
         m_err = 0;
         m_err_cmd = 64'h0;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".ready"},    64'(o_cmd_ready), 64'(m_ready()));
      chk({tag, ".cu_valid"}, 64'(o_cu_valid),  64'(m_cu_v));
      chk({tag, ".vpu_valid"},64'(o_vpu_valid), 64'(m_pend));
      chk({tag, ".err"},      64'(o_err),       64'(m_err));
      chk({tag, ".err_cmd"},  o_err_cmd,        m_err_cmd);
      chk({tag, ".busy"},     64'(o_busy),      64'(m_busy()));
      if (m_cu_v)
         chk({tag, ".cu_fields"}, 64'({o_cu_nop, o_cu_sync, o_cu_sync_stop, o_cu_sync_intr}),
             64'({m_nop, m_sync, m_stop, m_intr}));
      if (m_pend != 4'h0)
         chk({tag, ".vpu_fields"}, 64'({o_vpu_op, o_vpu_th, o_vpu_pl}),
             64'({m_op, m_th, m_pl}));
   endtask

   // Inputs are already applied at the negedge; check, advance, next negedge.
   task automatic cycle(input string tag);
      #1;
      check_state(tag);
      $display("txn %s t=%0t valid=%0b cmd=%016h ready=%0b vpu_valid=%b cu_valid=%0b err=%0b",
               tag, $time, i_cmd_valid, i_cmd, o_cmd_ready, o_vpu_valid, o_cu_valid, o_err);
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, ".cu_valid"},  64'(o_cu_valid), 64'h0);
      chk({tag, ".vpu_valid"}, 64'(o_vpu_valid), 64'h0);
      chk({tag, ".err"},       64'(o_err), 64'h0);
      chk({tag, ".err_cmd"},   o_err_cmd, 64'h0);
      chk({tag, ".busy"},      64'(o_busy), 64'h0);
      chk({tag, ".data"}, 64'({o_vpu_op, o_vpu_th, o_vpu_pl, o_cu_nop, o_cu_sync,
                               o_cu_sync_stop, o_cu_sync_intr}), 64'h0);
   endtask

   function automatic logic [63:0] rand_cmd();
      logic [4:0]  op;
      logic [7:0]  dst;
      logic [2:0]  z;
      logic [47:0] pl;
      int          k, hi, lo;
      k = $urandom_range(0, 15);
      case (k)
         0: op = CU_CMD_NOP;     1: op = CU_CMD_SYNC;
         2: op = CU_CMD_SETACC;  3: op = CU_CMD_SETVL;
         4: op = CU_CMD_SETRS;   5: op = CU_CMD_SETRT;
         6: op = CU_CMD_SETRD;   7: op = CU_CMD_SETEN;
         8, 9: op = CU_CMD_PROD;
         10, 11: op = CU_CMD_STORE;
         12, 13: op = CU_CMD_ACTF;
         default: op = 5'($urandom);
      endcase
      if (op >= 5'd16)
         dst = ($urandom_range(0, 1) == 0) ? 8'h00 : {5'($urandom_range(0, 4)), 3'b001};
      else if (op < 5'd4)
         dst = 8'h00;
      else
         dst = {5'($urandom_range(0, 4)), 3'($urandom)};
      if ($urandom_range(0, 7) == 0) dst = 8'($urandom);
      z  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      pl = {16'($urandom), 32'($urandom)};
      if (op == CU_CMD_ACTF) pl[47:42] = 6'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0 && rsv_range(op, pl, hi, lo))
         pl = pl & ~48'(range_bits(hi, lo));
      return mk(op, dst, z, pl);
   endfunction

   localparam logic [63:0] W_SYNC = 64'h0800_0000_0000_0003;

   initial begin
      logic [63:0] w;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      reset_check("reset");
      chk("reset.ready", 64'(o_cmd_ready), 64'h1);
      nrst = 1'b1;
      @(negedge clk);

      // SYNC to the CU sequencer
      i_cmd = W_SYNC; i_cmd_valid = 1; i_cu_ready = 1;
      cycle("t1_acc");
      i_cmd_valid = 0;
      #1;
      chk("t1.sync_flags", 64'({o_cu_valid, o_cu_sync, o_cu_sync_stop, o_cu_sync_intr, o_cu_nop}),
          64'b11110);
      cycle("t1_issue");
      #1;
      chk("t1.one_cycle", 64'(o_cu_valid), 64'h0);
      cycle("t1_idle");

      // broadcast PROD drained by two VPU halves, then SETVL back-to-back
      i_cmd = mk(CU_CMD_PROD, 8'h00, 3'd0, 48'h0); i_cmd_valid = 1; i_vpu_ready = 4'b0000;
      cycle("t2_acc");
      i_cmd_valid = 0; i_vpu_ready = 4'b0101;
      #1;
      chk("t2.valid_all", 64'(o_vpu_valid), 64'hF);
      chk("t2.ready_low", 64'(o_cmd_ready), 64'h0);
      cycle("t2_half");
      i_vpu_ready = 4'b1010; i_cmd = mk(CU_CMD_SETVL, 8'h10, 3'd0, 48'hA_BCDE); i_cmd_valid = 1;
      #1;
      chk("t2.valid_rest", 64'(o_vpu_valid), 64'hA);
      chk("t2.ready_final", 64'(o_cmd_ready), 64'h1);
      cycle("t2_last");
      i_cmd_valid = 0; i_vpu_ready = 4'b0100;
      #1;
      chk("t3.valid", 64'(o_vpu_valid), 64'h4);
      chk("t3.pl", 64'(o_vpu_pl), 64'h0000_000A_BCDE);
      chk("t3.th", 64'(o_vpu_th), 64'h0);
      cycle("t3_issue");

      // out-of-range VPU index
      w = mk(CU_CMD_SETVL, 8'h28, 3'd0, 48'h1);
      i_cmd = w; i_cmd_valid = 1; i_vpu_ready = 4'hF; i_cu_ready = 1;
      #1;
      chk("t4.consumed", 64'(o_cmd_ready), 64'h1);
      cycle("t4_acc");
      i_cmd_valid = 0; i_err_clr = 1;
      #1;
      chk("t4.err", 64'(o_err), 64'h1);
      chk("t4.err_cmd", o_err_cmd, w);
      chk("t4.ready", 64'(o_cmd_ready), 64'h0);
      chk("t4.no_issue", 64'({o_vpu_valid, o_cu_valid}), 64'h0);
      cycle("t4_clr");
      i_err_clr = 0; i_cmd = 64'h0; i_cmd_valid = 1;
      #1;
      chk("t4.resume", 64'({o_err, o_cmd_ready}), 64'b01);
      cycle("t4_nop");
      i_cmd_valid = 0;
      #1;
      chk("t4.nop", 64'({o_cu_valid, o_cu_nop}), 64'b11);
      cycle("t4_nop_issue");

      // NOP with a reserved payload bit: error here, issued without checks
      i_cmd = mk(CU_CMD_NOP, 8'h00, 3'd0, 48'h8); i_cmd_valid = 1; cmd_valid2 = 1;
      #1;
      chk("t5.nofmt_ready", 64'(o2_cmd_ready), 64'h1);
      cycle("t5_acc");
      i_cmd_valid = 0; cmd_valid2 = 0;
      #1;
      chk("t5.fmt_err", 64'(o_err), 64'h1);
      chk("t5.nofmt_nop", 64'({o2_cu_valid, o2_cu_nop, o2_err}), 64'b110);
      i_err_clr = 1;
      cycle("t5_clr");
      i_err_clr = 0;
      cycle("t5_idle");

      // ten back-to-back STOREs to VPU0
      i_cmd = mk(CU_CMD_STORE, 8'h01, 3'd0, 48'h0); i_cmd_valid = 1; i_vpu_ready = 4'hF;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            #1;
            chk($sformatf("t6.stream%0d", i), 64'(o_vpu_valid), 64'h1);
         end
         cycle("t6_store");
      end
      i_cmd_valid = 0;
      #1;
      chk("t6.stream10", 64'(o_vpu_valid), 64'h1);
      cycle("t6_tail");
      cycle("t6_idle");

      // reset in the middle of a stream
      i_cmd_valid = 1; i_vpu_ready = 4'h0;
      i_cmd = mk(CU_CMD_PROD, 8'h00, 3'd0, 48'h0);
      cycle("t6_bc");
      cycle("t6_hold");
      #1;
      nrst = 1'b0;
      #1;
      reset_check("t6_reset");
      model_reset();
      @(negedge clk);
      nrst = 1'b1; i_cmd_valid = 0;
      cycle("t6_after");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         i_cmd_valid = ($urandom_range(0, 3) != 0);
         i_cmd       = rand_cmd();
         i_cu_ready  = 1'($urandom);
         i_vpu_ready = 4'($urandom);
         i_err_clr   = ($urandom_range(0, 3) == 0);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
